// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding and the default frame start marker.
package uart_pkg;

  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } framer_state_t;

  // States in which the inter-byte idle timer is allowed to run.
  function automatic logic is_counting_state(input framer_state_t s);
    return (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/uart_rx_framer_counter.sv
// Idle counter: counts enabled cycles since the last clear and flags the
// cycle in which the LIMIT-th enabled cycle is being counted.
module uart_rx_framer_counter #(
  parameter int LIMIT = 10000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Count enabled cycles, holding at the limit so the hit flag stays asserted
  // until the owner clears or disables the counter.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !hit) begin
      count <= count + 1'b1;
    end
  end

  assign hit = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_rx_framer.sv
// Frame extractor for a byte stream from uart_rx. A frame is SYNC, LEN,
// LEN payload bytes and a checksum byte that makes the modular sum of LEN,
// the payload and the checksum zero. Good payloads are buffered, then
// offered on a valid/ready stream.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(UART_SYNC_BYTE),
  parameter int               MAX_LEN   = 16,
  parameter int               TIMEOUT   = 10000
) (
  input  logic                             clk,
  input  logic                             i_reset,
  input  logic [WIDTH-1:0]                 i_data,
  input  logic                             i_data_valid,
  output logic [WIDTH-1:0]                 o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_last,
  output logic [$clog2(MAX_LEN+1)-1:0]     o_pkt_len,
  output logic                             o_len_err,
  output logic                             o_crc_err,
  output logic                             o_timeout,
  output logic                             o_overrun
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  framer_state_t state;
  framer_state_t next_state;

  logic [WIDTH-1:0] buffer [MAX_LEN];
  logic [LW-1:0]    len;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] check_sum;

  logic counting;
  logic timeout_hit;
  logic len_bad;
  logic wr_last;
  logic rd_last;
  logic sum_ok;

  logic load_len;
  logic wr_en;
  logic start_drain;
  logic drain_adv;
  logic len_err_d;
  logic crc_err_d;
  logic timeout_d;
  logic overrun_d;

  assign counting  = is_counting_state(state);
  assign len_bad   = (i_data == '0) || (i_data > WIDTH'(MAX_LEN));
  assign wr_last   = (LW'(wr_idx) == (len - LW'(1)));
  assign rd_last   = (LW'(rd_idx) == (len - LW'(1)));
  assign check_sum = acc + i_data;
  assign sum_ok    = (check_sum == '0);
  assign drain_adv = (state == ST_DRAIN) && i_ready;

  // An arriving byte clears the idle count, so a byte landing on the timeout
  // cycle wins over the timeout.
  uart_rx_framer_counter #(
    .LIMIT (TIMEOUT)
  ) u_idle_counter (
    .clk     (clk),
    .i_reset (i_reset),
    .clear   (i_data_valid || !counting),
    .enable  (counting),
    .hit     (timeout_hit)
  );

  // State register.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_HUNT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-cycle datapath/error strobes.
  always_comb begin
    next_state  = state;
    load_len    = 1'b0;
    wr_en       = 1'b0;
    start_drain = 1'b0;
    len_err_d   = 1'b0;
    crc_err_d   = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = 1'b0;
    case (state)
      ST_HUNT: begin
        if (i_data_valid && (i_data == SYNC_BYTE)) begin
          next_state = ST_LEN;
        end
      end
      ST_LEN: begin
        if (i_data_valid) begin
          if (len_bad) begin
            len_err_d  = 1'b1;
            next_state = ST_HUNT;
          end else begin
            load_len   = 1'b1;
            next_state = ST_PAYLOAD;
          end
        end else if (timeout_hit) begin
          timeout_d  = 1'b1;
          next_state = ST_HUNT;
        end
      end
      ST_PAYLOAD: begin
        if (i_data_valid) begin
          wr_en = 1'b1;
          if (wr_last) begin
            next_state = ST_CHECK;
          end
        end else if (timeout_hit) begin
          timeout_d  = 1'b1;
          next_state = ST_HUNT;
        end
      end
      ST_CHECK: begin
        if (i_data_valid) begin
          if (sum_ok) begin
            start_drain = 1'b1;
            next_state  = ST_DRAIN;
          end else begin
            crc_err_d  = 1'b1;
            next_state = ST_HUNT;
          end
        end else if (timeout_hit) begin
          timeout_d  = 1'b1;
          next_state = ST_HUNT;
        end
      end
      ST_DRAIN: begin
        if (i_data_valid) begin
          overrun_d = 1'b1;
        end
        if (i_ready && rd_last) begin
          next_state = ST_HUNT;
        end
      end
      default: begin
        next_state = ST_HUNT;
      end
    endcase
  end

  // Length, indices, running checksum and registered error pulses.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      acc       <= '0;
      o_len_err <= 1'b0;
      o_crc_err <= 1'b0;
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_len_err <= len_err_d;
      o_crc_err <= crc_err_d;
      o_timeout <= timeout_d;
      o_overrun <= overrun_d;
      if (load_len) begin
        len    <= LW'(i_data);
        wr_idx <= '0;
        acc    <= i_data;
      end
      if (wr_en) begin
        wr_idx <= wr_idx + 1'b1;
        acc    <= check_sum;
      end
      if (start_drain) begin
        rd_idx <= '0;
      end else if (drain_adv) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Payload storage; contents are only meaningful once a frame passes its check.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer[wr_idx] <= i_data;
    end
  end

  assign o_valid   = (state == ST_DRAIN);
  assign o_data    = o_valid ? buffer[rd_idx] : '0;
  assign o_last    = o_valid && rd_last;
  assign o_pkt_len = o_valid ? len : '0;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed testbench for uart_rx_framer with hand-computed frames.
module tb_uart_rx_framer;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 20;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             i_reset;
  logic [WIDTH-1:0] i_data;
  logic             i_data_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;
  logic             o_last;
  logic [LW-1:0]    o_pkt_len;
  logic             o_len_err;
  logic             o_crc_err;
  logic             o_timeout;
  logic             o_overrun;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] capData[$];
  logic       capLast[$];
  int validCycles = 0;
  int lenErrCnt   = 0;
  int crcErrCnt   = 0;
  int timeoutCnt  = 0;
  int overrunCnt  = 0;

  always #5 clk = ~clk;

  uart_rx_framer #(
    .WIDTH     (WIDTH),
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAX_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_last       (o_last),
    .o_pkt_len    (o_pkt_len),
    .o_len_err    (o_len_err),
    .o_crc_err    (o_crc_err),
    .o_timeout    (o_timeout),
    .o_overrun    (o_overrun)
  );

  // Mid-cycle monitor: records accepted stream bytes and counts error pulses.
  always @(negedge clk) begin
    if (o_valid) validCycles++;
    if (o_valid && i_ready) begin
      capData.push_back(o_data);
      capLast.push_back(o_last);
    end
    if (o_len_err) lenErrCnt++;
    if (o_crc_err) crcErrCnt++;
    if (o_timeout) timeoutCnt++;
    if (o_overrun) overrunCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Presents one byte for exactly one cycle; entered and left 2ns after a rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    i_data       = b;
    i_data_valid = 1'b1;
    @(posedge clk);
    #2;
    i_data_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clearCapture();
    capData.delete();
    capLast.delete();
    validCycles = 0;
    lenErrCnt   = 0;
    crcErrCnt   = 0;
    timeoutCnt  = 0;
    overrunCnt  = 0;
  endtask

  task automatic checkDrainByte(input string tag, input int idx, input logic [7:0] expData, input logic expLast);
    checkOutput({tag, "Data"}, (idx < capData.size()) ? 32'(capData[idx]) : 32'hFFFF_FFFF, 32'(expData));
    checkOutput({tag, "Last"}, (idx < capLast.size()) ? 32'(capLast[idx]) : 32'hFFFF_FFFF, 32'(expLast));
  endtask

  task automatic checkOutputsZero(input string tag);
    checkOutput({tag, "Valid"}, 32'(o_valid), 32'd0);
    checkOutput({tag, "Last"}, 32'(o_last), 32'd0);
    checkOutput({tag, "PktLen"}, 32'(o_pkt_len), 32'd0);
    checkOutput({tag, "Data"}, 32'(o_data), 32'd0);
    checkOutput({tag, "Errs"}, 32'({o_len_err, o_crc_err, o_timeout, o_overrun}), 32'd0);
  endtask

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset      = 1'b1;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutputsZero("reset");
    i_reset = 1'b0;
    idleCycles(2);

    // Good three-byte frame streamed with the consumer always ready.
    clearCapture();
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
    applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h97);
    checkOutput("goodValid", 32'(o_valid), 32'd1);
    checkOutput("goodPktLen", 32'(o_pkt_len), 32'd3);
    checkOutput("goodFirst", 32'(o_data), 32'h11);
    idleCycles(4);
    checkOutput("goodCount", 32'(capData.size()), 32'd3);
    checkDrainByte("good0", 0, 8'h11, 1'b0);
    checkDrainByte("good1", 1, 8'h22, 1'b0);
    checkDrainByte("good2", 2, 8'h33, 1'b1);
    checkOutput("goodErrs", 32'(lenErrCnt + crcErrCnt + timeoutCnt + overrunCnt), 32'd0);
    checkOutput("goodIdle", 32'(o_valid), 32'd0);

    // Bad checksum: one crc pulse, nothing offered.
    clearCapture();
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
    applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h98);
    checkOutput("crcPulse", 32'(o_crc_err), 32'd1);
    idleCycles(3);
    checkOutput("crcCount", 32'(crcErrCnt), 32'd1);
    checkOutput("crcNoValid", 32'(validCycles), 32'd0);

    // Zero and oversize lengths; the trailing bytes would be a good frame only
    // if the FSM had not returned to HUNT.
    clearCapture();
    applyStimulus(8'hA5); applyStimulus(8'h00);
    checkOutput("lenZeroPulse", 32'(o_len_err), 32'd1);
    applyStimulus(8'hA5); applyStimulus(8'h11);
    checkOutput("lenBigPulse", 32'(o_len_err), 32'd1);
    applyStimulus(8'h01); applyStimulus(8'h55); applyStimulus(8'hAA);
    idleCycles(3);
    checkOutput("lenErrCount", 32'(lenErrCnt), 32'd2);
    checkOutput("lenHuntNoValid", 32'(validCycles), 32'd0);

    // Timeout after a stalled frame, then a single-byte frame.
    clearCapture();
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h11);
    idleCycles(TIMEOUT - 1);
    checkOutput("toNotEarly", 32'(o_timeout), 32'd0);
    idleCycles(1);
    checkOutput("toPulse", 32'(o_timeout), 32'd1);
    idleCycles(1);
    checkOutput("toPulseEnd", 32'(o_timeout), 32'd0);
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h7F); applyStimulus(8'h80);
    checkOutput("singleData", 32'(o_data), 32'h7F);
    checkOutput("singleLast", 32'(o_last), 32'd1);
    checkOutput("singlePktLen", 32'(o_pkt_len), 32'd1);
    idleCycles(2);
    checkOutput("singleCount", 32'(capData.size()), 32'd1);
    checkDrainByte("single0", 0, 8'h7F, 1'b1);
    checkOutput("toCount", 32'(timeoutCnt), 32'd1);

    // A byte arriving on the timeout cycle wins.
    clearCapture();
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h11);
    idleCycles(TIMEOUT - 1);
    applyStimulus(8'h22);
    checkOutput("raceNoTimeout", 32'(o_timeout), 32'd0);
    applyStimulus(8'hCB);
    idleCycles(3);
    checkOutput("raceCount", 32'(capData.size()), 32'd2);
    checkDrainByte("race0", 0, 8'h11, 1'b0);
    checkDrainByte("race1", 1, 8'h22, 1'b1);
    checkOutput("raceToCount", 32'(timeoutCnt), 32'd0);

    // Consumer stall, with a stray byte injected during DRAIN.
    clearCapture();
    i_ready = 1'b0;
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h11);
    applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h97);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallValid", 32'(o_valid), 32'd1);
      checkOutput("stallData", 32'(o_data), 32'h11);
      checkOutput("stallLast", 32'(o_last), 32'd0);
      checkOutput("stallPktLen", 32'(o_pkt_len), 32'd3);
      idleCycles(1);
    end
    applyStimulus(8'h5A);
    checkOutput("overrunPulse", 32'(o_overrun), 32'd1);
    checkOutput("overrunData", 32'(o_data), 32'h11);
    idleCycles(1);
    checkOutput("overrunPulseEnd", 32'(o_overrun), 32'd0);
    checkOutput("stallNoAccept", 32'(capData.size()), 32'd0);
    i_ready = 1'b1;
    idleCycles(4);
    checkOutput("overrunDrainCount", 32'(capData.size()), 32'd3);
    checkDrainByte("ovr0", 0, 8'h11, 1'b0);
    checkDrainByte("ovr1", 1, 8'h22, 1'b0);
    checkDrainByte("ovr2", 2, 8'h33, 1'b1);
    checkOutput("overrunCount", 32'(overrunCnt), 32'd1);

    // Asynchronous reset mid-frame, then a clean frame.
    clearCapture();
    applyStimulus(8'h00); applyStimulus(8'hFF); applyStimulus(8'hA5);
    applyStimulus(8'h02); applyStimulus(8'h10);
    #4;
    i_reset = 1'b1;
    #1;
    checkOutputsZero("rstFrame");
    @(posedge clk);
    #2;
    i_reset = 1'b0;
    applyStimulus(8'h20); applyStimulus(8'hCE);
    idleCycles(3);
    checkOutput("rstFrameNoValid", 32'(validCycles), 32'd0);
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h10);
    applyStimulus(8'h20); applyStimulus(8'hCE);
    idleCycles(4);
    checkOutput("cleanCount", 32'(capData.size()), 32'd2);
    checkDrainByte("clean0", 0, 8'h10, 1'b0);
    checkDrainByte("clean1", 1, 8'h20, 1'b1);

    // Asynchronous reset while a frame is being offered.
    clearCapture();
    i_ready = 1'b0;
    applyStimulus(8'hA5); applyStimulus(8'h01); applyStimulus(8'h7F); applyStimulus(8'h80);
    checkOutput("preRstValid", 32'(o_valid), 32'd1);
    checkOutput("preRstLast", 32'(o_last), 32'd1);
    #4;
    i_reset = 1'b1;
    #1;
    checkOutputsZero("rstDrain");
    @(posedge clk);
    #2;
    i_reset = 1'b0;
    i_ready = 1'b1;
    idleCycles(3);
    checkOutput("rstDrainNoAccept", 32'(capData.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter WIDTH, 8, byte width shared with the uart_rx instance feeding this block.
REQ-002 Parameter SYNC_BYTE, 8'hA5, frame start marker.
REQ-003 Parameter MAX_LEN, 16, maximum payload bytes per frame (1..255).
REQ-004 Parameter TIMEOUT, 10000, inter-byte idle clk cycles before frame abort (>=2).
REQ-005 clk  input  1  sole clock; all logic is on posedge clk.
REQ-006 i_reset  input  1  reset, asynchronous, active-high.
REQ-007 i_data  input  WIDTH  received byte from uart_rx; qualified by i_data_valid.
REQ-008 i_data_valid  input  1  single-cycle strobe, one per received byte.
REQ-009 o_data  output  WIDTH  payload byte being offered.
REQ-010 o_valid  output  1  o_data valid (valid/ready stream).
REQ-011 i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
REQ-012 o_last  output  1  high with the final payload byte of a frame.
REQ-013 o_pkt_len  output  $clog2(MAX_LEN+1)  length of the frame being drained; 0 otherwise.
REQ-014 o_len_err, o_crc_err, o_timeout, o_overrun  output  1 each  single-cycle error pulses.

Function
REQ-015 The frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, checksum byte C.
REQ-016 A frame SHALL be valid only when (LEN + sum of payload + C) mod 2^WIDTH == 0.
REQ-017 The FSM SHALL have states HUNT, LEN, PAYLOAD, CHECK, DRAIN; transitions SHALL occur only on an i_data_valid cycle, a timeout, or the final DRAIN handshake.
REQ-018 HUNT: bytes != SYNC_BYTE SHALL be discarded silently; SYNC_BYTE -> LEN.
REQ-019 LEN: LEN==0 or LEN>MAX_LEN -> o_len_err pulse, HUNT; otherwise store LEN, clear write index and checksum accumulator (seeded with LEN), -> PAYLOAD.
REQ-020 PAYLOAD: each byte SHALL be written to buffer[index] and added to the accumulator; after byte LEN-1 -> CHECK.
REQ-021 CHECK: checksum pass -> DRAIN with read index 0; fail -> o_crc_err pulse, HUNT; no payload byte SHALL be presented from a failing frame.
REQ-022 DRAIN: o_valid=1, o_data=buffer[read index], o_last=(read index==LEN-1); read index advances only on o_valid && i_ready; the handshake with o_last -> HUNT on the next cycle.
REQ-023 While o_valid && !i_ready, o_data, o_last and o_pkt_len SHALL remain stable.
REQ-024 An i_data_valid during DRAIN SHALL discard the byte and pulse o_overrun in the following cycle; buffer contents SHALL be unaffected.
REQ-025 The idle counter SHALL clear on every i_data_valid and count clk cycles in LEN, PAYLOAD, CHECK; upon reaching TIMEOUT -> o_timeout pulse, HUNT.
REQ-026 If i_data_valid coincides with the timeout cycle, the byte SHALL take precedence and no timeout SHALL occur.
REQ-027 Error pulses SHALL be registered, asserted exactly one cycle after the causing byte or timeout.
REQ-028 Accumulator arithmetic SHALL be WIDTH bits and wrap modulo 2^WIDTH.
REQ-029 Back-to-back frames SHALL be accepted once HUNT is re-entered, with zero extra idle cycles required.

Reset
REQ-030 On i_reset assertion, state SHALL go to HUNT immediately, regardless of clock; o_valid, o_last, o_pkt_len, o_data and all error pulses SHALL be 0; counters and indices SHALL be cleared.
REQ-031 Buffer contents SHALL NOT require reset.
REQ-032 A reset mid-frame or mid-DRAIN SHALL abandon the frame with no further output.

Structure
REQ-033 The state enum typedef and the default SYNC_BYTE constant SHALL be placed in the shared package uart_pkg.
REQ-034 The idle timeout SHALL be implemented with the existing counter sub-module; the buffer SHALL be a MAX_LEN x WIDTH register array inside this module.

Verification
REQ-035 Input A5 03 11 22 33 97 -> o_pkt_len=3; o_data 11,22,33 streamed, o_last with 33; no error pulses.
REQ-036 Input A5 03 11 22 33 98 -> one o_crc_err pulse; o_valid never asserted.
REQ-037 Input A5 00, then A5 11 (MAX_LEN=16) -> two o_len_err pulses; FSM in HUNT after each.
REQ-038 Input A5 02 11, then idle for TIMEOUT cycles -> o_timeout pulses exactly once; a following A5 01 7F 80 yields single byte 7F with o_last.
REQ-039 Valid frame with i_ready held low for 5 cycles -> o_data stable throughout; a byte injected then -> o_overrun pulse, and the drained payload is unchanged.
REQ-040 Input 00 FF A5 02 10 20 CE with i_reset asserted asynchronously after byte 10 -> outputs 0 immediately; no o_valid; the next clean frame is accepted.
